ex_mem_pipe: RTL

Parametrised EX→MEM pipeline stage register with a valid/ready handshake, an optional one-entry skid buffer, flush (bubble) support and control-field masking. It sits between the execute stage (ALU, branch adder) and the memory stage. It carries the WB and MEM control bundles, branch target, ALU zero flag, ALU result, store data and destination register. Back-pressure from the memory stage is absorbed without stalling execute for one cycle.

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/pipe_slot.sv | 55 +++++
 rtl/ex_mem_pipe.sv | 116 +++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// +----------------------------------------------------------------------------+
// | pipe_pkg : default widths and MEM-bundle bit indices shared by all the     |
// |            pipeline stage registers.                                       |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package pipe_pkg;

  localparam int DATA_W       = 32;
  localparam int REG_AW       = 5;
  localparam int WB_W         = 2;
  localparam int MEM_W        = 5;

  localparam int BRANCH_BIT   = 2;
  localparam int MEMREAD_BIT  = 1;
  localparam int MEMWRITE_BIT = 0;

endpackage

`default_nettype wire

// File: rtl/pipe_slot.sv
// +----------------------------------------------------------------------------+
// | pipe_slot : one pipeline slot, a valid bit plus a packed field register    |
// |             with load, drop and clear (flush) controls.                    |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module pipe_slot #(
  parameter int           W        = 8,
  parameter logic [W-1:0] CLR_MASK = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         drop_i,
  input  logic         clear_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // Clear beats load beats drop; cleared control bits read as zero afterwards.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
      data_d  = data_q & ~CLR_MASK;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (drop_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

`default_nettype wire

// File: rtl/ex_mem_pipe.sv
// +----------------------------------------------------------------------------+
// | ex_mem_pipe : EX->MEM stage register with valid/ready handshake, optional  |
// |               skid slot, flush and bubble masking of control bundles.      |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module ex_mem_pipe #(
  parameter int DATA_W     = pipe_pkg::DATA_W,
  parameter int REG_AW     = pipe_pkg::REG_AW,
  parameter int WB_W       = pipe_pkg::WB_W,
  parameter int MEM_W      = pipe_pkg::MEM_W,
  parameter int BRANCH_BIT = pipe_pkg::BRANCH_BIT,
  parameter int SKID       = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic [WB_W-1:0]   wb_in,
  input  logic [MEM_W-1:0]  mem_in,
  input  logic [DATA_W-1:0] adder_in,
  input  logic              zero_in,
  input  logic [DATA_W-1:0] alu_in,
  input  logic [DATA_W-1:0] rd2_in,
  input  logic [REG_AW-1:0] dest_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WB_W-1:0]   wb_out,
  output logic [MEM_W-1:0]  mem_out,
  output logic [DATA_W-1:0] adder_out,
  output logic              zero_out,
  output logic [DATA_W-1:0] alu_out,
  output logic [DATA_W-1:0] rd2_out,
  output logic [REG_AW-1:0] dest_out,
  output logic              branch_taken
);

  localparam int CTRL_W = WB_W + MEM_W;
  localparam int REC_W  = CTRL_W + 3 * DATA_W + 1 + REG_AW;
  // Control bundles sit in the top bits of the record and are zeroed on flush.
  localparam logic [REC_W-1:0] CTRL_MASK = {{CTRL_W{1'b1}}, {(REC_W - CTRL_W){1'b0}}};

  logic [REC_W-1:0]  w_in_rec;
  logic [REC_W-1:0]  w_main_d;
  logic [REC_W-1:0]  w_main_rec;
  logic [REC_W-1:0]  w_skid_rec;
  logic              w_main_valid;
  logic              w_skid_valid;
  logic              w_main_load;
  logic              w_accept;
  logic              w_consume;
  logic [WB_W-1:0]   w_wb;
  logic [MEM_W-1:0]  w_mem;

  assign w_in_rec  = {wb_in, mem_in, adder_in, zero_in, alu_in, rd2_in, dest_in};
  assign w_accept  = in_valid & in_ready;
  assign w_consume = w_main_valid & out_ready;
  assign w_main_d  = w_skid_valid ? w_skid_rec : w_in_rec;

  generate
    if (SKID != 0) begin : g_skid
      logic w_skid_load;

      // Registered ready: no combinational path from out_ready to in_ready.
      assign in_ready    = ~w_skid_valid;
      assign w_main_load = w_skid_valid ? w_consume
                                        : (w_accept & (~w_main_valid | w_consume));
      assign w_skid_load = w_accept & w_main_valid & ~w_consume;

      pipe_slot #(
        .W        (REC_W),
        .CLR_MASK (CTRL_MASK)
      ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (w_skid_load),
        .drop_i  (w_consume),
        .clear_i (flush),
        .data_i  (w_in_rec),
        .valid_o (w_skid_valid),
        .data_o  (w_skid_rec)
      );
    end else begin : g_no_skid
      assign in_ready     = ~w_main_valid | out_ready;
      assign w_main_load  = w_accept;
      assign w_skid_valid = 1'b0;
      assign w_skid_rec   = '0;
    end
  endgenerate

  pipe_slot #(
    .W        (REC_W),
    .CLR_MASK (CTRL_MASK)
  ) u_main (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (w_main_load),
    .drop_i  (w_consume),
    .clear_i (flush),
    .data_i  (w_main_d),
    .valid_o (w_main_valid),
    .data_o  (w_main_rec)
  );

  assign {w_wb, w_mem, adder_out, zero_out, alu_out, rd2_out, dest_out} = w_main_rec;

  assign out_valid    = w_main_valid;
  assign wb_out       = w_wb  & {WB_W{w_main_valid}};
  assign mem_out      = w_mem & {MEM_W{w_main_valid}};
  assign branch_taken = mem_out[BRANCH_BIT] & zero_out & w_main_valid;

endmodule

`default_nettype wire
